encoder_4to2: RTL and testbench



---
 rtl/encoder_4to2_if.sv | 20 ++
 rtl/encoder_4to2.sv | 51 +++++
 tb/tb_encoder_4to2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/encoder_4to2_if.sv
// rtl/encoder_4to2_if.sv - request/code bundle between requester and encoder_4to2
interface encoder_4to2_if;
  logic       enb;
  logic [3:0] i;
  logic       a;
  logic       b;
  logic       valid;
  logic       err;
  logic       err_sticky;

  modport master (
    output enb, i,
    input  a, b, valid, err, err_sticky
  );

  modport slave (
    input  enb, i,
    output a, b, valid, err, err_sticky
  );
endinterface

// File: rtl/encoder_4to2.sv
// rtl/encoder_4to2.sv - registered 4-to-2 priority encoder with valid/err flags
// Highest set request wins; multi-bit requests raise err and latch err_sticky.
module encoder_4to2 (
  input  logic            clk,
  input  logic            rst_n,
  encoder_4to2_if.slave   bus
);

  logic [1:0] code_d, code_q;
  logic       valid_d, valid_q;
  logic       err_d, err_q;
  logic       sticky_d, sticky_q;

  always_comb begin
    code_d   = 2'b00;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    if (bus.enb) begin
      if (bus.i[3])      code_d = 2'd3;
      else if (bus.i[2]) code_d = 2'd2;
      else if (bus.i[1]) code_d = 2'd1;
      else               code_d = 2'd0;
      valid_d = |bus.i;
      // Clearing the lowest set bit leaves something only if two or more were set
      err_d    = (bus.i & (bus.i - 4'd1)) != 4'd0;
      sticky_d = sticky_q | err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= 2'b00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.a          = code_q[1];
  assign bus.b          = code_q[0];
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_encoder_4to2.sv
// tb/tb_encoder_4to2.sv - directed and exhaustive checks for encoder_4to2
module tb_encoder_4to2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder_4to2_if bus ();

  encoder_4to2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       enb;
    logic [3:0] i;
    logic [1:0] code;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_sticky = 1'b0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] code,
                           input logic v, input logic e, input logic s);
    chk({tag, ".code"}, {bus.a, bus.b}, code);
    chk({tag, ".valid"}, {1'b0, bus.valid}, {1'b0, v});
    chk({tag, ".err"}, {1'b0, bus.err}, {1'b0, e});
    chk({tag, ".sticky"}, {1'b0, bus.err_sticky}, {1'b0, s});
  endtask

  // Called at a negedge: drive, let one rising edge pass, check at the next negedge
  task automatic apply(input string tag, input logic enb, input logic [3:0] iv,
                       input logic [1:0] code, input logic v, input logic e);
    bus.enb = enb;
    bus.i   = iv;
    @(posedge clk);
    @(negedge clk);
    exp_sticky = exp_sticky | e;
    check_out(tag, code, v, e, exp_sticky);
  endtask

  // Independent reference: scan for the top set bit and count set bits
  task automatic model(input logic enb, input logic [3:0] iv,
                       output logic [1:0] code, output logic v, output logic e);
    int ones;
    code = 2'b00;
    ones = 0;
    for (int k = 0; k < 4; k++) begin
      if (iv[k]) begin
        code = k[1:0];
        ones++;
      end
    end
    v = enb && (ones > 0);
    e = enb && (ones > 1);
    if (!enb) code = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] mc;
    logic       mv, me;

    vecs.push_back('{1'b1, 4'b0001, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 2'b10, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0110, 2'b10, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0001, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 2'b11, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b1000, 2'b11, 1'b1, 1'b0});

    // Reset held with an active request on the inputs
    bus.enb = 1'b1;
    bus.i   = 4'b1000;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset_held", 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check_out("reset_held_after_edge", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("reset_release", 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0);

    foreach (vecs[n])
      apply($sformatf("vec%0d", n), vecs[n].enb, vecs[n].i,
            vecs[n].code, vecs[n].valid, vecs[n].err);

    // Asynchronous reset between edges while code=11 and sticky set
    check_out("pre_async", 2'b11, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    exp_sticky = 1'b0;
    check_out("async_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("async_reset_hold", 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int en = 0; en < 2; en++) begin
      for (int v = 0; v < 16; v++) begin
        model(en[0], v[3:0], mc, mv, me);
        apply($sformatf("exh_enb%0d_i%0h", en, v), en[0], v[3:0], mc, mv, me);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
